// File: rtl/sfm_pkg.sv
// Shared softmax types and BF16 constants used by the normalisation stage.
package sfm_pkg;

    localparam int unsigned BF16_EXP_W = 8;
    localparam int unsigned BF16_MAN_W = 7;
    localparam int unsigned BF16_BIAS  = 127;
    localparam logic [15:0] BF16_QNAN  = 16'h7FC0;

    typedef enum logic [1:0] {
        StIdle,
        StWaitRecip,
        StScaling,
        StDrain
    } norm_state_t;

    typedef struct packed {
        logic busy;
        logic done;
    } norm_flags_t;

endpackage

// File: rtl/sfm_bf16_mul.sv
// Combinational single-lane BF16 multiplier: RNE rounding, flush-to-zero subnormals.
module sfm_bf16_mul
    import sfm_pkg::*;
(
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    output logic [15:0] p_o
);

    localparam int unsigned EW = BF16_EXP_W;
    localparam int unsigned MW = BF16_MAN_W;

    logic          sa, sb, s;
    logic [EW-1:0] ea, eb;
    logic [MW-1:0] ma, mb;
    logic          a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [15:0]   prod;
    logic [MW-1:0] man_t;
    logic          guard, sticky, rnd;
    logic [8:0]    man_r;
    logic [10:0]   exp_n;

    always_comb begin
        sa = a_i[15];
        sb = b_i[15];
        ea = a_i[14:7];
        eb = b_i[14:7];
        ma = a_i[6:0];
        mb = b_i[6:0];
        s  = sa ^ sb;

        a_nan  = (&ea) & (|ma);
        b_nan  = (&eb) & (|mb);
        a_inf  = (&ea) & ~(|ma);
        b_inf  = (&eb) & ~(|mb);
        a_zero = ~(|ea);
        b_zero = ~(|eb);

        prod = {8'b0, 1'b1, ma} * {8'b0, 1'b1, mb};

        // Product of two 1.x significands lies in [1,4); normalise on bit 15.
        if (prod[15]) begin
            man_t  = prod[14:8];
            guard  = prod[7];
            sticky = |prod[6:0];
        end else begin
            man_t  = prod[13:7];
            guard  = prod[6];
            sticky = |prod[5:0];
        end
        rnd   = guard & (sticky | man_t[0]);
        man_r = {1'b0, 1'b1, man_t} + {8'b0, rnd};

        // 11-bit two's complement: bit 10 set means the result underflowed.
        exp_n = {3'b0, ea} + {3'b0, eb} + {10'b0, prod[15]} + {10'b0, man_r[8]}
              - 11'(BF16_BIAS);

        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            p_o = BF16_QNAN;
        end else if (a_inf || b_inf) begin
            p_o = {s, 8'hFF, 7'h00};
        end else if (a_zero || b_zero) begin
            p_o = {s, 15'h0000};
        end else if (exp_n[10] || (exp_n == 11'd0)) begin
            p_o = {s, 15'h0000};
        end else if (exp_n >= 11'd255) begin
            p_o = {s, 8'hFF, 7'h00};
        end else begin
            p_o = {s, exp_n[7:0], man_r[6:0]};
        end
    end

endmodule

// File: rtl/sfm_norm_scaler.sv
// Softmax normalisation: latches the BF16 reciprocal and scales every lane of a
// streamed vector through a globally stalled multiplier pipeline.
module sfm_norm_scaler
    import sfm_pkg::*;
#(
    parameter int unsigned N_LANES  = 4,
    parameter int unsigned MUL_REGS = 2,
    parameter int unsigned LEN_W    = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    clear_i,
    input  logic                    start_i,
    input  logic [LEN_W-1:0]        len_i,
    input  logic [15:0]             recip_i,
    input  logic                    recip_valid_i,
    input  logic [16*N_LANES-1:0]   in_data_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    output logic [16*N_LANES-1:0]   out_data_o,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic                    busy_o,
    output logic                    done_o
);

    localparam int unsigned DW = 16 * N_LANES;

    norm_state_t       state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  in_cnt_q, in_cnt_d;
    logic [LEN_W-1:0]  out_cnt_q, out_cnt_d;
    logic [15:0]       recip_q, recip_d;
    norm_flags_t       flags_q, flags_d;
    logic [MUL_REGS-1:0] vld_q, vld_d;
    logic [DW-1:0]     data_q [MUL_REGS];
    logic [DW-1:0]     data_d [MUL_REGS];

    logic [DW-1:0]     mul_out;
    logic              pipe_en, in_fire, out_fire, done_d;

    for (genvar k = 0; k < N_LANES; k++) begin : g_lane
        sfm_bf16_mul u_mul (
            .a_i (in_data_i[16*k +: 16]),
            .b_i (recip_q),
            .p_o (mul_out[16*k +: 16])
        );
    end

    assign out_valid_o = vld_q[MUL_REGS-1];
    assign out_data_o  = data_q[MUL_REGS-1];
    assign pipe_en     = ~out_valid_o | out_ready_i;
    assign in_ready_o  = (state_q == StScaling) & pipe_en & (in_cnt_q < len_q);
    assign in_fire     = in_valid_i & in_ready_o;
    assign out_fire    = out_valid_o & out_ready_i;
    assign busy_o      = flags_q.busy;
    assign done_o      = flags_q.done;

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        recip_d   = recip_q;
        done_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    if (len_i == '0) begin
                        done_d = 1'b1;
                    end else begin
                        len_d     = len_i;
                        in_cnt_d  = '0;
                        out_cnt_d = '0;
                        if (recip_valid_i) begin
                            recip_d = recip_i;
                            state_d = StScaling;
                        end else begin
                            state_d = StWaitRecip;
                        end
                    end
                end
            end
            StWaitRecip: begin
                if (recip_valid_i) begin
                    recip_d = recip_i;
                    state_d = StScaling;
                end
            end
            StScaling: begin
                if (in_fire) begin
                    in_cnt_d = in_cnt_q + LEN_W'(1);
                    if (in_cnt_q == len_q - LEN_W'(1)) state_d = StDrain;
                end
            end
            StDrain: ;
            default: state_d = StIdle;
        endcase

        // The last output beat can only arrive after the last input, i.e. in StDrain.
        if (out_fire) begin
            out_cnt_d = out_cnt_q + LEN_W'(1);
            if ((state_q == StDrain) && (out_cnt_q == len_q - LEN_W'(1))) begin
                state_d = StIdle;
                done_d  = 1'b1;
            end
        end

        flags_d.busy = (state_d != StIdle);
        flags_d.done = done_d;
    end

    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        if (pipe_en) begin
            vld_d[0]  = in_fire;
            data_d[0] = mul_out;
            for (int i = 1; i < MUL_REGS; i++) begin
                vld_d[i]  = vld_q[i-1];
                data_d[i] = data_q[i-1];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            state_q   <= StIdle;
            len_q     <= '0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            recip_q   <= '0;
            flags_q   <= '0;
            vld_q     <= '0;
            for (int i = 0; i < MUL_REGS; i++) data_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            recip_q   <= recip_d;
            flags_q   <= flags_d;
            vld_q     <= vld_d;
            for (int i = 0; i < MUL_REGS; i++) data_q[i] <= data_d[i];
        end
    end

endmodule

// File: tb/tb_sfm_norm_scaler.sv
// Scoreboard bench for sfm_norm_scaler: random jobs against an arithmetic BF16 model.
module tb_sfm_norm_scaler;

    localparam int N_LANES  = 4;
    localparam int MUL_REGS = 2;
    localparam int LEN_W    = 16;
    localparam int DW       = 16 * N_LANES;

    logic             clk = 1'b0;
    logic             rst_i, clear_i, start_i;
    logic [LEN_W-1:0] len_i;
    logic [15:0]      recip_i;
    logic             recip_valid_i;
    logic [DW-1:0]    in_data_i;
    logic             in_valid_i, in_ready_o;
    logic [DW-1:0]    out_data_o;
    logic             out_valid_o, out_ready_i;
    logic             busy_o, done_o;

    sfm_norm_scaler #(
        .N_LANES  (N_LANES),
        .MUL_REGS (MUL_REGS),
        .LEN_W    (LEN_W)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .clear_i       (clear_i),
        .start_i       (start_i),
        .len_i         (len_i),
        .recip_i       (recip_i),
        .recip_valid_i (recip_valid_i),
        .in_data_i     (in_data_i),
        .in_valid_i    (in_valid_i),
        .in_ready_o    (in_ready_o),
        .out_data_o    (out_data_o),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i),
        .busy_o        (busy_o),
        .done_o        (done_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        int            in_cyc;
        bit            chk_lat;
    } exp_t;

    exp_t          sb_q[$];
    int            errors = 0;
    int            checks = 0;
    int            cyc = 0;
    int            done_cnt = 0;
    int            ready_mode = 0;
    bit            ignore_stall = 0;
    bit            prev_stall = 0;
    logic [DW-1:0] prev_data = '0;
    logic [DW-1:0] beats [16];
    logic [DW-1:0] exps  [16];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: exact integer product, then generic round-to-nearest-even to 8 bits.
    function automatic logic [15:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
        int ea = int'(a[14:7]);
        int eb = int'(b[14:7]);
        int ma = int'(a[6:0]);
        int mb = int'(b[6:0]);
        bit s  = a[15] ^ b[15];
        bit a_nan = (ea == 255) && (ma != 0);
        bit b_nan = (eb == 255) && (mb != 0);
        bit a_inf = (ea == 255) && (ma == 0);
        bit b_inf = (eb == 255) && (mb == 0);
        bit a_zero = (ea == 0);
        bit b_zero = (eb == 0);
        int p, e, sh, q, rem, half;
        logic [15:0] r;
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) return 16'h7FC0;
        if (a_inf || b_inf) return {s, 15'h7F80};
        if (a_zero || b_zero) return {s, 15'h0000};
        p  = (128 + ma) * (128 + mb);
        sh = 0;
        while ((p >> sh) >= 256) sh++;
        q    = p >> sh;
        rem  = p - (q << sh);
        half = 1 << (sh - 1);
        if (rem > half || (rem == half && q[0])) q++;
        if (q == 256) begin
            q = 128;
            sh++;
        end
        e = ea + eb - 127 + sh - 7;
        if (e <= 0) return {s, 15'h0000};
        if (e >= 255) return {s, 15'h7F80};
        r = {s, e[7:0], q[6:0]};
        return r;
    endfunction

    function automatic logic [DW-1:0] ref_beat(input logic [DW-1:0] beat, input logic [15:0] rc);
        logic [DW-1:0] r;
        for (int k = 0; k < N_LANES; k++) r[16*k +: 16] = ref_mul(beat[16*k +: 16], rc);
        return r;
    endfunction

    function automatic logic [15:0] rand_normal(input int lo, input int hi);
        logic [15:0] v;
        v = {1'($urandom_range(0, 1)), 8'($urandom_range(lo, hi)), 7'($urandom_range(0, 127))};
        return v;
    endfunction

    task automatic fill_job(input int n, input logic [15:0] rc);
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < N_LANES; k++) begin
                beats[i][16*k +: 16] = ($urandom_range(0, 7) == 0) ? 16'($urandom)
                                                                  : rand_normal(90, 170);
            end
            exps[i] = ref_beat(beats[i], rc);
        end
    endtask

    // Output ready: 0 = always, 1 = random stalls, 2 = held low.
    initial begin
        out_ready_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_ready_i = 1'b1;
                1:       out_ready_i = 1'($urandom_range(0, 1));
                default: out_ready_i = 1'b0;
            endcase
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (done_o) done_cnt++;
            if (prev_stall && !ignore_stall) begin
                check("stall_valid", 64'(out_valid_o), 64'd1);
                check("stall_data", out_data_o, prev_data);
            end
            if (out_valid_o && !out_ready_i) check("stall_in_ready", 64'(in_ready_o), 64'd0);
            if (out_valid_o && out_ready_i) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got %h expected none", out_data_o);
                end else begin
                    e = sb_q.pop_front();
                    check("out_data", out_data_o, e.data);
                    if (e.chk_lat) check("latency", 64'(cyc - e.in_cyc), 64'(MUL_REGS));
                end
            end
            prev_stall = out_valid_o && !out_ready_i;
            prev_data  = out_data_o;
        end
    end

    task automatic start_job(input int n, input logic [15:0] rc, input bit rv);
        start_i       = 1'b1;
        len_i         = LEN_W'(n);
        recip_i       = rc;
        recip_valid_i = rv;
        @(posedge clk);
        #1;
        start_i = 1'b0;
    endtask

    task automatic feed(input int n, input bit rand_valid, input bit lat);
        int i = 0;
        int budget = 0;
        exp_t e;
        while (i < n && budget < 1000) begin
            in_valid_i = rand_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_data_i  = beats[i];
            @(negedge clk);
            if (in_valid_i && in_ready_o) begin
                e.data    = exps[i];
                e.in_cyc  = cyc;
                e.chk_lat = lat;
                sb_q.push_back(e);
                i++;
            end
            @(posedge clk);
            #1;
            budget++;
        end
        in_valid_i = 1'b0;
        if (i < n) begin
            checks++;
            errors++;
            $display("FAIL feed_timeout: accepted %0d beats, required %0d", i, n);
        end
    endtask

    task automatic wait_done(input string name, input int d0);
        for (int k = 0; k < 500; k++) begin
            @(posedge clk);
            if (done_cnt != d0) break;
        end
        repeat (3) @(posedge clk);
        #1;
        check({name, "_done_pulses"}, 64'(done_cnt - d0), 64'd1);
        check({name, "_idle"}, 64'(busy_o), 64'd0);
        check({name, "_sb_empty"}, 64'(sb_q.size()), 64'd0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        logic [15:0] rc;
        logic [15:0] sp_a [5] = '{16'h7F00, 16'h7FC0, 16'h7F80, 16'h0001, 16'hC000};
        logic [15:0] sp_b [5] = '{16'h4000, 16'h4040, 16'h0000, 16'h3F80, 16'h3E80};
        logic [15:0] sp_p [5] = '{16'h7F80, 16'h7FC0, 16'h7FC0, 16'h0000, 16'hBF00};
        int d0, n;

        rst_i = 1'b1; clear_i = 1'b0; start_i = 1'b0; len_i = '0; recip_i = '0;
        recip_valid_i = 1'b0; in_data_i = '0; in_valid_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_i = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready_o), 64'd0);
        check("rst_out_valid", 64'(out_valid_o), 64'd0);
        check("rst_out_data", out_data_o, 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_done", 64'(done_o), 64'd0);
        @(posedge clk);
        #1;

        // Basic job with constant expectations and latency check.
        beats[0] = {4{16'h4000}};
        beats[1] = {4{16'h3F80}};
        exps[0]  = {4{16'h3F00}};
        exps[1]  = {4{16'h3E80}};
        d0 = done_cnt;
        start_job(2, 16'h3E80, 1'b1);
        recip_valid_i = 1'b0;
        feed(2, 1'b0, 1'b1);
        wait_done("basic", d0);

        // Backpressure with random stalls on both sides.
        ready_mode = 1;
        for (int j = 0; j < 2; j++) begin
            n  = (j == 0) ? 8 : 13;
            rc = rand_normal(110, 140);
            fill_job(n, rc);
            d0 = done_cnt;
            start_job(n, rc, 1'b1);
            recip_valid_i = 1'b0;
            feed(n, 1'b1, 1'b0);
            wait_done("backpressure", d0);
        end
        ready_mode = 0;

        // Reciprocal arrives 5 cycles after start; later recip changes are ignored.
        rc = 16'h3F40;
        fill_job(3, rc);
        d0 = done_cnt;
        start_job(3, 16'h1234, 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 0 || k == 4) begin
                check("wait_busy", 64'(busy_o), 64'd1);
                check("wait_in_ready", 64'(in_ready_o), 64'd0);
            end
            @(posedge clk);
            #1;
        end
        recip_valid_i = 1'b1;
        recip_i       = rc;
        @(negedge clk);
        check("recip_edge_in_ready", 64'(in_ready_o), 64'd0);
        @(posedge clk);
        #1;
        recip_i = 16'hDEAD;
        @(negedge clk);
        check("recip_next_in_ready", 64'(in_ready_o), 64'd1);
        @(posedge clk);
        #1;
        feed(3, 1'b0, 1'b0);
        recip_valid_i = 1'b0;
        wait_done("recip_late", d0);

        // Reciprocal valid in the start cycle.
        rc = rand_normal(120, 135);
        fill_job(2, rc);
        d0 = done_cnt;
        start_job(2, rc, 1'b1);
        recip_valid_i = 1'b0;
        @(negedge clk);
        check("same_cycle_in_ready", 64'(in_ready_o), 64'd1);
        @(posedge clk);
        #1;
        feed(2, 1'b0, 1'b0);
        wait_done("recip_same", d0);

        // Special values on lane 0, checked against fixed results.
        for (int j = 0; j < 5; j++) begin
            fill_job(1, sp_b[j]);
            beats[0][15:0] = sp_a[j];
            exps[0][15:0]  = sp_p[j];
            d0 = done_cnt;
            start_job(1, sp_b[j], 1'b1);
            recip_valid_i = 1'b0;
            feed(1, 1'b0, 1'b0);
            wait_done("special", d0);
        end

        // Zero-length job.
        d0 = done_cnt;
        start_job(0, 16'h3F80, 1'b0);
        @(negedge clk);
        check("len0_done", 64'(done_o), 64'd1);
        check("len0_busy", 64'(busy_o), 64'd0);
        repeat (3) @(negedge clk);
        check("len0_busy_later", 64'(busy_o), 64'd0);
        check("len0_done_once", 64'(done_cnt - d0), 64'd1);
        @(posedge clk);
        #1;

        // Clear while two beats are in flight in DRAIN.
        ready_mode = 2;
        @(posedge clk);
        #1;
        rc = rand_normal(120, 135);
        fill_job(2, rc);
        start_job(2, rc, 1'b1);
        recip_valid_i = 1'b0;
        feed(2, 1'b0, 1'b0);
        @(negedge clk);
        check("pre_clear_valid", 64'(out_valid_o), 64'd1);
        @(posedge clk);
        #1;
        d0 = done_cnt;
        ignore_stall = 1'b1;
        clear_i = 1'b1;
        sb_q.delete();
        @(posedge clk);
        #1;
        clear_i = 1'b0;
        ready_mode = 0;
        @(negedge clk);
        check("clear_out_valid", 64'(out_valid_o), 64'd0);
        check("clear_busy", 64'(busy_o), 64'd0);
        check("clear_done", 64'(done_o), 64'd0);
        repeat (4) @(posedge clk);
        #1;
        ignore_stall = 1'b0;
        check("clear_no_done", 64'(done_cnt - d0), 64'd0);

        // Unity reciprocal passes normal data through unchanged.
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < N_LANES; k++) beats[i][16*k +: 16] = rand_normal(1, 254);
            exps[i] = beats[i];
        end
        d0 = done_cnt;
        start_job(4, 16'h3F80, 1'b1);
        recip_valid_i = 1'b0;
        feed(4, 1'b0, 1'b0);
        wait_done("unity", d0);

        // Random jobs.
        ready_mode = 1;
        for (int j = 0; j < 6; j++) begin
            n  = $urandom_range(1, 10);
            rc = ($urandom_range(0, 5) == 0) ? 16'($urandom) : rand_normal(100, 150);
            fill_job(n, rc);
            d0 = done_cnt;
            start_job(n, rc, 1'b1);
            recip_valid_i = 1'b0;
            feed(n, 1'b1, 1'b0);
            wait_done("random", d0);
        end
        ready_mode = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sfm_norm_scaler.md
Name: sfm_norm_scaler

Overview:
- Normalisation stage directly downstream of the softmax accumulator.
- Latches the reciprocal of the denominator (BF16) when the accumulator signals inversion done.
- Streams a vector of exponentiated scores, multiplying every lane by that reciprocal in a stall-able multiplier pipeline.
- Emits the normalised softmax outputs with a valid/ready handshake.

Parameters:
- N_LANES, 4, BF16 elements per beat.
- MUL_REGS, 2, pipeline registers after the lane multipliers (legal range 1..4); sets latency.
- LEN_W, 16, width of the beat-count input.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- clear_i  in  1  synchronous soft clear; same effect as rst_i.
- start_i  in  1  starts a job; sampled only in IDLE.
- len_i  in  LEN_W  number of input beats for the job; sampled with start_i.
- recip_i  in  16  BF16 reciprocal (accumulator reciprocal output).
- recip_valid_i  in  1  reciprocal valid (accumulator inv_done level).
- in_data_i  in  16*N_LANES  BF16 scores; lane k at bits [16k+15:16k].
- in_valid_i  in  1  input beat valid.
- in_ready_o  out  1  input beat ready.
- out_data_o  out  16*N_LANES  normalised BF16 lanes.
- out_valid_o  out  1  output beat valid.
- out_ready_i  in  1  downstream ready.
- busy_o  out  1  state != IDLE.
- done_o  out  1  one-cycle pulse when the job completes.

Behaviour:
- Reset and clear (rst_i or clear_i high at a clock edge):
  - State goes to IDLE; counters, reciprocal register and all pipeline valids go to 0.
  - All outputs read 0 the next cycle.
  - Either signal mid-job drops in-flight beats with no done_o.
- FSM states: IDLE, WAIT_RECIP, SCALING, DRAIN.
- IDLE:
  - start_i & len_i==0: pulse done_o next cycle, stay IDLE.
  - start_i & len_i>0: latch len_i. If recip_valid_i is high the same cycle, latch recip_i and go to SCALING; otherwise go to WAIT_RECIP.
- WAIT_RECIP: on recip_valid_i, latch recip_i and go to SCALING.
- SCALING:
  - in_ready_o = pipe_en & (in_cnt < len).
  - An input handshake increments in_cnt.
  - The handshake of beat len-1 moves the state to DRAIN.
- DRAIN: in_ready_o=0. The out_valid_o&out_ready_i handshake of beat len-1 returns the state to IDLE and pulses done_o on the following cycle.
- Pipeline enable: pipe_en = ~out_valid_o | out_ready_i.
  - A global stall: all MUL_REGS stages hold when pipe_en=0.
  - Bubbles are not compressed.
- Latency is exactly MUL_REGS cycles from input handshake to out_valid_o, with no backpressure. Full throughput is 1 beat/cycle.
- Output ordering is strict FIFO. out_data_o holds stable while out_valid_o & ~out_ready_i.
- out_cnt counts output handshakes; in_cnt and out_cnt are LEN_W bits and never wrap within a job.
- The reciprocal register holds constant for the whole job. Changes on recip_i / recip_valid_i after latching are ignored.
- start_i outside IDLE is ignored.
- BF16 multiply, per lane:
  - Sign is the XOR of the input signs.
  - Exponent is the sum minus bias 127; the 8x8 mantissa product uses hidden bits.
  - Rounding is round-to-nearest-even on the product.
  - Subnormal inputs and results flush to signed zero.
  - Exponent overflow gives signed infinity.
  - NaN operand, or inf*0, gives 0x7FC0.
  - inf*finite-nonzero gives signed infinity.

Decomposition:
- In the shared package sfm_pkg:
  - BF16 field widths and bias constants (BF16_EXP_W=8, BF16_MAN_W=7, BF16_BIAS=127).
  - BF16_QNAN=16'h7FC0.
  - Enum norm_state_t.
  - Struct norm_flags_t {busy, done} for the top-level controller.
- One sub-module, sfm_bf16_mul: purely combinational single-lane multiplier, instantiated N_LANES times. The top block owns the FSM, counters, reciprocal register and pipeline registers.

Test Plan:
- Basic job (N_LANES=4, MUL_REGS=2):
  - Stimulus: recip 0x3E80 (0.25), len=2, in beats 0x4000 (2.0) and 0x3F80 (1.0) on all lanes, out_ready_i held 1.
  - Required: outputs 0x3F00 then 0x3E80, the first 2 cycles after its input handshake; done_o pulses once.
- Backpressure:
  - Stimulus: len=8 with random out_ready_i stalls.
  - Required: no beat lost or duplicated; out_data_o stable during stalls; in_ready_o=0 whenever out_valid_o & ~out_ready_i.
- Reciprocal ordering:
  - Stimulus: start_i with recip_valid_i=0.
  - Required: FSM sits in WAIT_RECIP with in_ready_o=0; when recip_valid_i rises 5 cycles later, the first input is accepted the cycle after.
  - Stimulus: start_i and recip_valid_i in the same cycle.
  - Required: in_ready_o=1 on the next cycle.
- Special values:
  - 0x7F00*0x4000 -> 0x7F80.
  - 0x7FC0*x -> 0x7FC0.
  - 0x7F80*0x0000 -> 0x7FC0.
  - 0x0001*0x3F80 -> 0x0000.
  - 0xC000*0x3E80 -> 0xBF00.
- len_i=0: done_o pulses the cycle after start_i; busy_o stays 0; no output beats.
- Clear mid-job:
  - Stimulus: clear_i asserted in DRAIN with 2 beats in flight.
  - Required: next cycle out_valid_o=0, busy_o=0, no done_o; a following job with recip 0x3F80 passes its data through unchanged.
